// File: rtl/ser_pkg.sv
// Shared types and helpers for the serial deserializer slice.
package ser_pkg;

    typedef enum logic {
        DIR_MSB_FIRST = 1'b0,
        DIR_LSB_FIRST = 1'b1
    } shift_dir_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } deser_state_e;

    // Counter width able to hold every value 0..frame_len.
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/deser_out_stage.sv
// Output holding register for the deserializer: valid/ready handshake,
// drop-on-full with a one-cycle overrun pulse, parity flag carried with the word.
module deser_out_stage #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [N-1:0] load_word,
    input  logic         load_perr,
    input  logic         word_ready,
    output logic [N-1:0] word_out,
    output logic         word_valid,
    output logic         overrun,
    output logic         parity_err
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                // A word that is still waiting wins over the newcomer unless
                // it is being consumed on this very edge.
                if (word_valid && !word_ready) begin
                    overrun <= 1'b1;
                end else begin
                    word_out   <= load_word;
                    word_valid <= 1'b1;
                    parity_err <= load_perr;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
                parity_err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: FSM, bit counter, shift register and output stage.
// Define DESER_PARITY_EN to append an even-parity bit to every frame.
//
// state    | meaning
// ST_IDLE  | waiting for the first bit of a frame
// ST_SHIFT | frame in progress, counting bits
module serial_deserializer
    import ser_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         dir,
    input  logic         abort,
    output logic [N-1:0] word_out,
    output logic         word_valid,
    input  logic         word_ready,
    output logic         busy,
    output logic         overrun,
    output logic         parity_err
);

`ifdef DESER_PARITY_EN
    localparam int FRAME_LEN = N + 1;
`else
    localparam int FRAME_LEN = N;
`endif
    localparam int             CW     = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0]  LAST_C = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0]  N_C    = CW'(N);

    deser_state_e  state, state_nx;
    shift_dir_e    dir_q, dir_nx, dir_use;
    logic [CW-1:0] cnt, cnt_nx;
    logic [N-1:0]  sreg, sreg_nx;
    logic          bit_ok;
    logic          done;
    logic          done_perr;

    assign bit_ok = sin_valid && !abort;
    assign busy   = (state == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            dir_q <= DIR_MSB_FIRST;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nx;
            dir_q <= dir_nx;
            cnt   <= cnt_nx;
            sreg  <= sreg_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dir_nx   = dir_q;
        cnt_nx   = cnt;
        sreg_nx  = sreg;
        done     = 1'b0;
        // The first bit of a frame must already follow the new direction.
        dir_use  = (state == ST_IDLE) ? shift_dir_e'(dir) : dir_q;

        case (state)
            ST_IDLE: begin
                if (bit_ok) begin
                    state_nx = ST_SHIFT;
                    dir_nx   = dir_use;
                    cnt_nx   = CW'(1);
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else if (sin_valid) begin
                    if (cnt == LAST_C) begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                        done     = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Only data bits enter the shift register; a trailing parity bit does not.
        if (bit_ok && (cnt < N_C)) begin
            if (dir_use == DIR_MSB_FIRST)
                sreg_nx = {sreg[N-2:0], sin};
            else
                sreg_nx = {sin, sreg[N-1:1]};
        end
    end

`ifdef DESER_PARITY_EN
    logic par_q, par_nx;

    always_comb begin
        par_nx = par_q;
        if (bit_ok)
            par_nx = ((state == ST_IDLE) ? 1'b0 : par_q) ^ sin;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            par_q <= 1'b0;
        else
            par_q <= par_nx;
    end

    // Running XOR over data and parity bits; nonzero means odd weight.
    assign done_perr = par_nx;
`else
    assign done_perr = 1'b0;
`endif

    deser_out_stage #(
        .N (N)
    ) u_out (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (done),
        .load_word  (sreg_nx),
        .load_perr  (done_perr),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

endmodule
